// File: rtl/smvm_result_collector_pkg.sv
// Shared SMVM definitions: default result word width, counter width and the
// result collector state encoding.
package smvm_result_collector_pkg;

  // Width of an SMVM result word (data_out).
  localparam int unsigned SmvmDw = 14;

  // Width of the job row, receive and pop counters.
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/smvm_result_collector_if.sv
// Result stream bundle for the SMVM result collector.
//   in_valid/in_data   : upstream SMVM results, no backpressure
//   out_valid/out_data : FIFO head offered downstream
//   out_ready          : downstream accepts the head word
//   out_last           : head word is the final word of the job
// master: the environment side (source of in_*, sink of out_*).
// slave : the collector side.
interface smvm_result_collector_if
  import smvm_result_collector_pkg::*;
#(
  parameter int unsigned DW = SmvmDw
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/smvm_res_fifo.sv
// First-word-fall-through result FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when popping)
//   push_data  : word to write
//   pop        : remove the head word (ignored when empty)
//   pop_data   : head word, reads 0 while empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
module smvm_res_fifo
  import smvm_result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = SmvmDw
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  output logic [DW-1:0]           pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full     = (cnt_q == LW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign level    = cnt_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/smvm_result_collector.sv
// SMVM result collector: buffers one job of result words from the SMVM core
// in a FWFT FIFO and streams them downstream, flagging the job's last word.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse starting a job (honoured only in IDLE)
//   rows_cfg   : expected word count, sampled on start (0 = empty job)
//   bus        : in_valid/in_data upstream, out_valid/out_data/out_ready/
//                out_last downstream
//   busy       : job in COLLECT or DRAIN
//   done       : one-cycle completion pulse
//   overflow   : sticky, a word was dropped during the job
//   level      : FIFO occupancy
module smvm_result_collector
  import smvm_result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = SmvmDw
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CntW-1:0]         rows_cfg,
  smvm_result_collector_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] rows_q, rcv_cnt_q, pop_cnt_q;
  logic            overflow_q;

  logic            fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0]   fifo_level;
  logic [DW-1:0]   fifo_head;
  logic            push_req, push_ok, drop_full, stray_in;
  logic            start_job, last_rcv, last_pop, out_last;

  // Upstream words are only taken while collecting; in IDLE they are ignored.
  assign push_req  = (state_q == StCollect) && bus.in_valid;
  assign fifo_pop  = !fifo_empty && bus.out_ready;
  assign push_ok   = push_req && (!fifo_full || fifo_pop);
  assign drop_full = push_req && fifo_full && !fifo_pop;
  assign stray_in  = bus.in_valid && ((state_q == StDrain) || (state_q == StDone));
  assign start_job = (state_q == StIdle) && start && (rows_cfg != '0);
  // Reception of word rows-1 ends collection even if the word was dropped.
  assign last_rcv  = push_req && (rcv_cnt_q == rows_q - CntW'(1));
  assign last_pop  = fifo_pop && out_last;

  smvm_res_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (bus.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = (rows_cfg != '0) ? StCollect : StDone;
      end
      StCollect: begin
        if (last_rcv) state_d = StDrain;
      end
      StDrain: begin
        // Second term covers jobs whose last word was dropped.
        if (last_pop || (fifo_empty && (rcv_cnt_q == rows_q))) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StCollect, StDrain: busy = 1'b1;
      StDone:             done = 1'b1;
      default:            ;
    endcase
    out_last = !fifo_empty && (pop_cnt_q == rows_q - CntW'(1));
  end

  // Job counters and sticky overflow; counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q     <= '0;
      rcv_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (start_job) begin
      rows_q     <= rows_cfg;
      rcv_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_req && (rcv_cnt_q != '1)) rcv_cnt_q <= rcv_cnt_q + CntW'(1);
      if (fifo_pop && (pop_cnt_q != '1)) pop_cnt_q <= pop_cnt_q + CntW'(1);
      if (drop_full || stray_in)         overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.out_last  = out_last;
  assign overflow      = overflow_q;
  assign level         = fifo_level;

endmodule

// File: tb/tb_smvm_result_collector.sv
module tb_smvm_result_collector;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 14;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rows_cfg;
  logic          busy, done, overflow;
  logic [LW-1:0] level;

  smvm_result_collector_if #(.DW(DW)) bus ();

  smvm_result_collector #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rows_cfg (rows_cfg),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_edge = -1;
  logic [DW-1:0] got_q[$];
  bit            last_q[$];

  // Reference: words popped downstream, recorded from the handshake.
  task automatic tick();
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      last_q.push_back(bus.out_last);
      pop_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    start        = 1'b0;
    rows_cfg     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic clear_capture();
    got_q.delete();
    last_q.delete();
    pop_edge = -1;
  endtask

  task automatic begin_job(input int rows);
    clear_capture();
    start    = 1'b1;
    rows_cfg = 8'(rows);
    tick();
    start    = 1'b0;
    rows_cfg = '0;
  endtask

  task automatic run_to_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, overflow, bus.out_valid, bus.out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, done, overflow, bus.out_valid, bus.out_last});
    end
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w [3] = '{14'h0005, 14'h3FFF, 14'h2000};
    bit seen;
    begin_job(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b want 1", busy);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    run_to_done(20, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL basic_done: got no done pulse want one");
    end
    checks++;
    if (pop_edge !== cyc) begin
      errors++; $display("FAIL basic_done_timing: last pop edge %0d done edge %0d", pop_edge, cyc);
    end
    checks++;
    if (got_q.size() !== 3) begin
      errors++; $display("FAIL basic_count: got %0d words want 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== w[i] || last_q[i] !== (i == 2)) begin
        errors++;
        $display("FAIL basic_word%0d: got %h last %b want %h last %b",
                 i, got_q[i], last_q[i], w[i], (i == 2));
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL basic_overflow: got %b want 0", overflow);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after: done %b busy %b want 0 0", done, busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    bit seen;
    int nlast;
    begin_job(20);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom());
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      exp_q.push_back(d);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (level !== LW'(DEPTH)) begin
      errors++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ovf_busy_drain: got %b want 1", busy);
    end
    bus.out_ready = 1'b1;
    run_to_done(60, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ovf_done: got no done pulse want one");
    end
    checks++;
    if (got_q.size() !== DEPTH) begin
      errors++; $display("FAIL ovf_count: got %0d words want %0d", got_q.size(), DEPTH);
    end
    nlast = 0;
    for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
      if (last_q[i]) nlast++;
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (nlast !== 0) begin
      errors++; $display("FAIL ovf_no_last: got %0d last flags want 0", nlast);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ovf_busy_fall: got %b want 0", busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    bit seen;
    begin_job(20);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom());
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      exp_q.push_back(d);
      tick();
    end
    checks++;
    if (level !== LW'(DEPTH) || overflow !== 1'b0) begin
      errors++; $display("FAIL full_fill: level %0d ovf %b want 16 0", level, overflow);
    end
    for (int i = 16; i < 20; i++) begin
      d = DW'($urandom());
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b1;
      exp_q.push_back(d);
      tick();
      checks++;
      if (level !== LW'(DEPTH)) begin
        errors++; $display("FAIL full_pp_level%0d: got %0d want 16", i, level);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++; $display("FAIL full_pp_ovf%0d: got %b want 0", i, overflow);
      end
    end
    bus.in_valid = 1'b0;
    run_to_done(60, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL full_done: got no done pulse want one");
    end
    checks++;
    if (got_q.size() !== 20) begin
      errors++; $display("FAIL full_count: got %0d words want 20", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 20; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 19)) begin
        errors++;
        $display("FAIL full_word%0d: got %h last %b want %h last %b",
                 i, got_q[i], last_q[i], exp_q[i], (i == 19));
      end
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero_rows();
    start    = 1'b1;
    rows_cfg = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_done: got %b want 1", done);
    end
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_busy_valid: busy %b valid %b want 0 0", busy, bus.out_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_midjob();
    logic [DW-1:0] w [2] = '{14'h1234, 14'h0ABC};
    bit seen;
    begin_job(8);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom());
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (level !== LW'(4)) begin
      errors++; $display("FAIL mid_level_before: got %0d want 4", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, bus.out_valid, bus.out_last} !== 5'b0 || level !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: flags %b level %0d want 00000 0",
               {busy, done, overflow, bus.out_valid, bus.out_last}, level);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %h want 0", bus.out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    begin_job(2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      tick();
    end
    bus.in_valid = 1'b0;
    run_to_done(20, seen);
    checks++;
    if (!seen || got_q.size() !== 2) begin
      errors++; $display("FAIL mid_next_job: done %b words %0d want 1 2", seen, got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== w[i] || last_q[i] !== (i == 1)) begin
        errors++;
        $display("FAIL mid_word%0d: got %h last %b want %h last %b",
                 i, got_q[i], last_q[i], w[i], (i == 1));
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL mid_overflow: got %b want 0", overflow);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_drain_extra();
    logic [DW-1:0] w [3] = '{14'h0111, 14'h2222, 14'h3333};
    bit seen;
    begin_job(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL extra_overflow: got %b want 1", overflow);
    end
    checks++;
    if (level !== LW'(2)) begin
      errors++; $display("FAIL extra_level: got %0d want 2", level);
    end
    bus.out_ready = 1'b1;
    run_to_done(20, seen);
    checks++;
    if (!seen || got_q.size() !== 2) begin
      errors++; $display("FAIL extra_stream: done %b words %0d want 1 2", seen, got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== w[i] || last_q[i] !== (i == 1)) begin
        errors++;
        $display("FAIL extra_word%0d: got %h last %b want %h last %b",
                 i, got_q[i], last_q[i], w[i], (i == 1));
      end
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Random jobs that fit the FIFO: the downstream stream must equal the
  // upstream words in order, with out_last only on the final one.
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d, prev_data;
    bit prev_hold, seen;
    int rows, sent;
    for (int j = 0; j < 25; j++) begin
      rows = int'($urandom_range(1, 16));
      exp_q.delete();
      begin_job(rows);
      sent = 0;
      seen = 1'b0;
      prev_hold = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 400 && !seen; c++) begin
        if (prev_hold) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
            errors++;
            $display("FAIL rnd_hold job%0d: valid %b data %h want 1 %h",
                     j, bus.out_valid, bus.out_data, prev_data);
          end
        end
        if (sent < rows && $urandom_range(0, 3) != 0) begin
          d = DW'($urandom());
          bus.in_valid = 1'b1;
          bus.in_data  = d;
          exp_q.push_back(d);
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        tick();
        if (done) seen = 1'b1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rnd_done job%0d: got no done pulse want one", j);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++; $display("FAIL rnd_overflow job%0d: got %b want 0", j, overflow);
      end
      checks++;
      if (got_q.size() !== rows) begin
        errors++; $display("FAIL rnd_count job%0d: got %0d want %0d", j, got_q.size(), rows);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || last_q[i] !== (i == rows - 1)) begin
          errors++;
          $display("FAIL rnd_word job%0d idx%0d: got %h last %b want %h last %b",
                   j, i, got_q[i], last_q[i], exp_q[i], (i == rows - 1));
        end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_zero_rows();
    test_reset_midjob();
    test_drain_extra();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
